// File: rtl/prco_lmem_arbiter_if.sv
// prco_lmem_arbiter_if: fetch, data and local-memory signals that the arbiter sits between.
interface prco_lmem_arbiter_if #(
    parameter int P_ADDR_W = 16,
    parameter int P_DATA_W = 16
);
    logic                i_f_req;
    logic [P_ADDR_W-1:0] i_f_addr;
    logic                q_f_done;
    logic [P_DATA_W-1:0] q_f_rdata;
    logic                i_d_req;
    logic                i_d_we;
    logic [P_ADDR_W-1:0] i_d_addr;
    logic [P_DATA_W-1:0] i_d_wdata;
    logic                q_d_done;
    logic [P_DATA_W-1:0] q_d_rdata;
    logic                q_mem_ce;
    logic                q_mem_we;
    logic [P_ADDR_W-1:0] q_mem_addr;
    logic [P_DATA_W-1:0] q_mem_dina;
    logic [P_DATA_W-1:0] i_mem_douta;
    logic                q_busy;
    logic                q_grant;
    modport master (
        output i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_douta,
        input  q_f_done, q_f_rdata, q_d_done, q_d_rdata, q_mem_ce, q_mem_we, q_mem_addr,
               q_mem_dina, q_busy, q_grant
    );
    modport slave (
        input  i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_douta,
        output q_f_done, q_f_rdata, q_d_done, q_d_rdata, q_mem_ce, q_mem_we, q_mem_addr,
               q_mem_dina, q_busy, q_grant
    );
endinterface

// File: rtl/prco_lmem_arbiter.sv
// prco_lmem_arbiter: shares single-ported local memory between fetch and load/store, bounding fetch starvation.
module prco_lmem_arbiter #(
    parameter int P_ADDR_W     = 16,
    parameter int P_DATA_W     = 16,
    parameter int P_MEM_LAT    = 1,
    parameter int P_STARVE_MAX = 3
) (
    input logic i_clk,
    input logic i_reset_n,
    prco_lmem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          state;
    logic [2:0]          wait_cnt;
    logic [3:0]          starve;
    logic                owner, ce, we, f_done, d_done, busy, take_d;
    logic [P_ADDR_W-1:0] addr;
    logic [P_DATA_W-1:0] dina, f_rdata, d_rdata;

    // fetch only wins a contested slot once it has been passed over P_STARVE_MAX times
    assign take_d = bus.i_d_req && !(bus.i_f_req && starve == 4'(P_STARVE_MAX));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            starve   <= '0;
            owner    <= 1'b0;
            ce       <= 1'b0;
            we       <= 1'b0;
            f_done   <= 1'b0;
            d_done   <= 1'b0;
            busy     <= 1'b0;
            addr     <= '0;
            dina     <= '0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            ce     <= 1'b0;
            we     <= 1'b0;
            f_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                S_IDLE: if (bus.i_f_req || bus.i_d_req) begin
                    state  <= S_ISSUE;
                    busy   <= 1'b1;
                    owner  <= take_d;
                    ce     <= 1'b1;
                    we     <= take_d && bus.i_d_we;
                    addr   <= take_d ? bus.i_d_addr : bus.i_f_addr;
                    dina   <= take_d ? bus.i_d_wdata : dina;
                    starve <= take_d ? starve + {3'b0, bus.i_f_req} : '0;
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= 3'(P_MEM_LAT - 1);
                end
                S_WAIT: if (wait_cnt == '0) begin
                    state   <= S_RESP;
                    f_done  <= !owner;
                    d_done  <= owner;
                    f_rdata <= owner ? f_rdata : bus.i_mem_douta;
                    d_rdata <= owner ? bus.i_mem_douta : d_rdata;
                end else begin
                    wait_cnt <= wait_cnt - 3'd1;
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q_mem_ce   = ce;
    assign bus.q_mem_we   = we;
    assign bus.q_mem_addr = addr;
    assign bus.q_mem_dina = dina;
    assign bus.q_f_done   = f_done;
    assign bus.q_f_rdata  = f_rdata;
    assign bus.q_d_done   = d_done;
    assign bus.q_d_rdata  = d_rdata;
    assign bus.q_busy     = busy;
    assign bus.q_grant    = owner;
endmodule
